cmos_tx: RTL and testbench

CMOS_TX -- requirements
Module: cmos_tx

---
 rtl/cmos_tx_if.sv | 18 +
 rtl/cmos_tx.sv | 203 ++++++++++++++++++++
 tb/tb_cmos_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cmos_tx_if.sv
// Camera-side parallel bus of the CMOS sensor emulator: frame sync, line valid and pixel byte.
interface cmos_tx_if;
  logic       cmos_vsync;
  logic       cmos_href;
  logic [7:0] cmos_din;

  modport master (
    output cmos_vsync,
    output cmos_href,
    output cmos_din
  );

  modport slave (
    input cmos_vsync,
    input cmos_href,
    input cmos_din
  );
endinterface

// File: rtl/cmos_tx.sv
// CMOS sensor emulator: frames of RGB565 test patterns sent as vsync/href/byte stream,
// high byte first. All outputs are registered from the next-state values.
module cmos_tx #(
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned VS_LEN = 2000,
  parameter int unsigned VBP    = 2000,
  parameter int unsigned HBLANK = 1000,
  parameter int unsigned VFP    = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [15:0]      solid_color,
  cmos_tx_if.master        cam,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned LineLen = 2 * H_ACT;
  localparam int unsigned Max0    = (VS_LEN > VBP) ? VS_LEN : VBP;
  localparam int unsigned Max1    = (HBLANK > VFP) ? HBLANK : VFP;
  localparam int unsigned Max2    = (Max0 > Max1) ? Max0 : Max1;
  localparam int unsigned CntMax  = (Max2 > LineLen) ? Max2 : LineLen;
  localparam int unsigned CW      = $clog2(CntMax);
  localparam int unsigned LW      = $clog2(V_ACT + 1);
  localparam int unsigned BarW    = H_ACT / 8;
  localparam int unsigned BW      = (BarW > 1) ? $clog2(BarW) : 1;
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrMask = 16'hB400;

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StAct, StHbl, StVfp} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   line_q, line_d;
  logic [BW-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     color_q, color_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      din_q, din_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_frame;
  logic [CW-2:0]   x_d;
  logic [15:0]     pix;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
  endfunction

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    line_d      = line_q;
    bar_cnt_d   = bar_cnt_q;
    bar_idx_d   = bar_idx_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    color_d     = color_q;
    start_frame = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) start_frame = 1'b1;
      end
      StVsync: begin
        if (cnt_q == CW'(VS_LEN - 1)) begin
          state_d = StVbp;
          cnt_d   = '0;
        end
      end
      StVbp: begin
        if (cnt_q == CW'(VBP - 1)) begin
          state_d   = StAct;
          cnt_d     = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
        end
      end
      StAct: begin
        // Pixel ends on its low byte: advance per-pixel generators.
        if (cnt_q[0]) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (bar_cnt_q == BW'(BarW - 1)) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + BW'(1);
          end
        end
        if (cnt_q == CW'(LineLen - 1)) begin
          state_d = StHbl;
          cnt_d   = '0;
          line_d  = line_q + LW'(1);
        end
      end
      StHbl: begin
        if (cnt_q == CW'(HBLANK - 1)) begin
          cnt_d     = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
          state_d   = (line_q < LW'(V_ACT)) ? StAct : StVfp;
        end
      end
      StVfp: begin
        if (cnt_q == CW'(VFP - 1)) begin
          cnt_d = '0;
          if (enable) start_frame = 1'b1;
          else        state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (start_frame) begin
      state_d = StVsync;
      cnt_d   = '0;
      line_d  = '0;
      lfsr_d  = LfsrSeed;
      mode_d  = mode;
      color_d = solid_color;
    end
  end

  // Pixel for the cycle being set up, derived from next-state counters.
  always_comb begin
    x_d = cnt_d[CW-1:1];
    unique case (mode_d)
      2'd0:    pix = 16'(x_d) + (16'(line_d) << 8);
      2'd1:    pix = bar_rgb(bar_idx_d);
      2'd2:    pix = color_d;
      default: pix = lfsr_d;
    endcase
    vsync_d = (state_d == StVsync);
    href_d  = (state_d == StAct);
    din_d   = href_d ? (cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StVfp) && (cnt_d == CW'(VFP - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      line_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      lfsr_q    <= LfsrSeed;
      mode_q    <= '0;
      color_q   <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cam.cmos_vsync = vsync_q;
  assign cam.cmos_href  = href_q;
  assign cam.cmos_din   = din_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_cmos_tx.sv
// Directed bench for cmos_tx with small frame parameters; pixel bytes are checked
// against a scoreboard queue filled from a reference pattern model.
module tb_cmos_tx;
  localparam int unsigned H   = 8;
  localparam int unsigned V   = 2;
  localparam int unsigned VSL = 3;
  localparam int unsigned VB  = 2;
  localparam int unsigned HB  = 4;
  localparam int unsigned VF  = 5;
  localparam int FRAME = VSL + VB + V * (2 * H + HB) + VF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        busy;
  logic        frame_done;

  cmos_tx_if cam_if ();

  cmos_tx #(
    .H_ACT (H),
    .V_ACT (V),
    .VS_LEN(VSL),
    .VBP   (VB),
    .HBLANK(HB),
    .VFP   (VF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .solid_color(solid_color),
    .cam        (cam_if),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] bar_color(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic [15:0] col);
    logic [15:0] l;
    logic [15:0] p;
    l = 16'hACE1;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        case (m)
          2'd0:    p = 16'(x + (y << 8));
          2'd1:    p = bar_color(x / (H / 8));
          2'd2:    p = col;
          default: p = l;
        endcase
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
        l = lfsr_next(l);
      end
    end
  endtask

  // Observes one frame starting at the vsync rise; optionally changes inputs mid-frame.
  task automatic capture_frame(input string tag, input int chg_at, input logic [1:0] chg_mode,
                               input logic [15:0] chg_col, input int drop_at,
                               input bit expect_next);
    int k;
    int vs_cnt, first_href, href_cnt, fd_cnt, fd_idx, both, dirty, idle;
    vs_cnt = 0; first_href = -1; href_cnt = 0; fd_cnt = 0; fd_idx = -1;
    both = 0; dirty = 0; idle = 0;
    k = 0;
    while (!cam_if.cmos_vsync && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " vsync_start"}, 32'(cam_if.cmos_vsync), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (cam_if.cmos_vsync) vs_cnt++;
      if (cam_if.cmos_href) begin
        href_cnt++;
        if (first_href < 0) first_href = i;
        if (exp_q.size() > 0) check({tag, " byte"}, 32'(cam_if.cmos_din), 32'(exp_q.pop_front()));
      end else if (cam_if.cmos_din !== 8'h00) begin
        dirty++;
      end
      if (cam_if.cmos_vsync && cam_if.cmos_href) both++;
      if (!busy) idle++;
      if (frame_done) begin
        fd_cnt++;
        fd_idx = i;
      end
      if (i == chg_at) begin
        mode        = chg_mode;
        solid_color = chg_col;
      end
      if (i == drop_at) enable = 1'b0;
    end
    @(negedge clk);
    check({tag, " vsync_len"}, 32'(vs_cnt), 32'(VSL));
    check({tag, " href_start"}, 32'(first_href), 32'(VSL + VB));
    check({tag, " href_cnt"}, 32'(href_cnt), 32'(2 * H * V));
    check({tag, " frame_done_cnt"}, 32'(fd_cnt), 32'd1);
    check({tag, " frame_done_pos"}, 32'(fd_idx), 32'(FRAME - 1));
    check({tag, " vsync_href_overlap"}, 32'(both), 32'd0);
    check({tag, " din_outside_act"}, 32'(dirty), 32'd0);
    check({tag, " busy_gap"}, 32'(idle), 32'd0);
    check({tag, " queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, " next_vsync"}, 32'(cam_if.cmos_vsync), 32'(expect_next));
    check({tag, " next_busy"}, 32'(busy), 32'(expect_next));
    exp_q.delete();
  endtask

  initial begin
    int vs_seen;
    int k;
    repeat (3) @(negedge clk);
    check("rst vsync", 32'(cam_if.cmos_vsync), 32'd0);
    check("rst href", 32'(cam_if.cmos_href), 32'd0);
    check("rst din", 32'(cam_if.cmos_din), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle no enable busy", 32'(busy), 32'd0);
    check("idle no enable vsync", 32'(cam_if.cmos_vsync), 32'd0);

    // Bars; mid-frame switch to LFSR must wait for the next frame.
    mode   = 2'd1;
    enable = 1'b1;
    push_frame(2'd1, 16'h0000);
    capture_frame("bars", 10, 2'd3, 16'h0000, -1, 1'b1);

    push_frame(2'd3, 16'h0000);
    capture_frame("lfsr1", -1, 2'd3, 16'h0000, -1, 1'b1);

    push_frame(2'd3, 16'h0000);
    capture_frame("lfsr2", 10, 2'd0, 16'h0000, -1, 1'b1);

    push_frame(2'd0, 16'h0000);
    capture_frame("grad", 10, 2'd2, 16'hF81F, -1, 1'b1);

    // Solid frame: colour change ignored mid-frame, enable dropped in the second line.
    push_frame(2'd2, 16'hF81F);
    capture_frame("solid", 12, 2'd2, 16'h1234, 30, 1'b0);

    vs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cam_if.cmos_vsync) vs_seen++;
    end
    check("after drop vsync", 32'(vs_seen), 32'd0);
    check("after drop busy", 32'(busy), 32'd0);

    // Reset during ACT.
    mode   = 2'd0;
    enable = 1'b1;
    k = 0;
    while (!cam_if.cmos_vsync && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (VSL + VB + 3) @(negedge clk);
    check("pre-reset href", 32'(cam_if.cmos_href), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset href", 32'(cam_if.cmos_href), 32'd0);
    check("reset vsync", 32'(cam_if.cmos_vsync), 32'd0);
    check("reset din", 32'(cam_if.cmos_din), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(2'd0, 16'h0000);
    capture_frame("post_reset", -1, 2'd0, 16'h0000, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
